// File: rtl/i2c_pkg.sv
// i2c_pkg: shared FSM states and bus-level constants for the I2C blocks
package i2c_pkg;
  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT_STOP
  } state_t;
  localparam logic I2C_WRITE = 1'b0;
  localparam logic I2C_READ = 1'b1;
  localparam logic ACK = 1'b0;
  localparam logic NACK = 1'b1;
endpackage

// File: rtl/i2c_target_regs_if.sv
// i2c_target_regs_if: sampled bus lines, open-drain SDA drive and write-strobe side port
interface i2c_target_regs_if #(parameter int AW = 4);
  logic scl_i;
  logic sda_i;
  logic sda_oe;
  logic wr_stb;
  logic [AW-1:0] wr_addr;
  logic [7:0] wr_data;
  logic busy;
  modport slave (input scl_i, sda_i, output sda_oe, wr_stb, wr_addr, wr_data, busy);
  modport master (output scl_i, sda_i, input sda_oe, wr_stb, wr_addr, wr_data, busy);
endinterface

// File: rtl/i2c_bus_sync.sv
// i2c_bus_sync: synchronises SCL/SDA and derives edge, START and STOP pulses
module i2c_bus_sync (
  input  logic clk,
  input  logic rst,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);
  logic scl_m, scl_s, scl_h, sda_m, sda_s, sda_h;
  // two-flop synchronisers plus a history stage; idle bus is high so reset to 1
  always_ff @(posedge clk or posedge rst)
    if (rst) {scl_m, scl_s, scl_h, sda_m, sda_s, sda_h} <= '1;
    else {scl_m, scl_s, scl_h, sda_m, sda_s, sda_h} <= {scl_i, scl_m, scl_s, sda_i, sda_m, sda_s};
  assign sda = sda_s;
  assign scl_rise = scl_s & ~scl_h;
  assign scl_fall = ~scl_s & scl_h;
  assign start_det = scl_s & scl_h & sda_h & ~sda_s;
  assign stop_det = scl_s & scl_h & ~sda_h & sda_s;
endmodule

// File: rtl/i2c_target_regs.sv
// i2c_target_regs: I2C target with a byte-wide register file and write-strobe port
module i2c_target_regs import i2c_pkg::*; #(
  parameter logic [6:0] DEV_ADDR = 7'h64,
  parameter int AW = 4,
  parameter logic [7:0] RST_VAL = 8'h00
) (
  input logic clk,
  input logic rst,
  i2c_target_regs_if.slave bus
);
  state_t state;
  logic [2:0] bitcnt;
  logic [7:0] shift, rx, wr_data;
  logic [7:0] mem [2**AW];
  logic [AW-1:0] ptr, ptr_n, wr_addr;
  logic rw, ackd, sda_oe, busy, wr_stb;
  logic sda, scl_rise, scl_fall, start_det, stop_det;
  i2c_bus_sync u_sync (
    .clk(clk), .rst(rst), .scl_i(bus.scl_i), .sda_i(bus.sda_i), .sda(sda),
    .scl_rise(scl_rise), .scl_fall(scl_fall), .start_det(start_det), .stop_det(stop_det)
  );
  assign rx = {shift[6:0], sda};
  assign ptr_n = ptr + 1'b1;
  assign bus.sda_oe = sda_oe;
  assign bus.wr_stb = wr_stb;
  assign bus.wr_addr = wr_addr;
  assign bus.wr_data = wr_data;
  assign bus.busy = busy;
  // protocol FSM: START/STOP override bit handling; ACK is driven for one full SCL low-high-low
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      bitcnt <= '0;
      shift <= '0;
      ptr <= '0;
      rw <= I2C_WRITE;
      ackd <= 1'b0;
      sda_oe <= 1'b0;
      busy <= 1'b0;
      wr_stb <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      mem <= '{default: RST_VAL};
    end else begin
      wr_stb <= 1'b0;
      if (stop_det) begin
        state <= IDLE;
        sda_oe <= 1'b0;
        busy <= 1'b0;
      end else if (start_det) begin
        state <= ADDR;
        bitcnt <= '0;
        sda_oe <= 1'b0;
        ackd <= 1'b0;
      end else
        case (state)
          ADDR, PTR, WDATA:
            if (scl_rise) begin
              shift <= rx;
              bitcnt <= bitcnt + 1'b1;
              if (bitcnt == 3'd7) begin
                ackd <= 1'b0;
                if (state == ADDR) begin
                  state <= rx[7:1] == DEV_ADDR ? ADDR_ACK : WAIT_STOP;
                  busy <= busy | (rx[7:1] == DEV_ADDR);
                  rw <= rx[0];
                end else if (state == PTR) begin
                  ptr <= rx[AW-1:0];
                  state <= PTR_ACK;
                end else begin
                  mem[ptr] <= rx;
                  wr_stb <= 1'b1;
                  wr_addr <= ptr;
                  wr_data <= rx;
                  ptr <= ptr_n;
                  state <= WDATA_ACK;
                end
              end
            end
          ADDR_ACK, PTR_ACK, WDATA_ACK:
            if (scl_fall) begin
              ackd <= ~ackd;
              sda_oe <= ~ackd;
              if (ackd) begin
                state <= state != ADDR_ACK ? WDATA : rw == I2C_READ ? RDATA : PTR;
                if (state == ADDR_ACK && rw == I2C_READ) begin
                  shift <= mem[ptr];
                  sda_oe <= ~mem[ptr][7];
                end
              end
            end
          RDATA: begin
            if (scl_fall) sda_oe <= ~shift[3'd7 - bitcnt];
            if (scl_rise) begin
              bitcnt <= bitcnt + 1'b1;
              if (bitcnt == 3'd7) state <= RDATA_ACK;
            end
          end
          RDATA_ACK: begin
            if (scl_fall) sda_oe <= 1'b0;
            if (scl_rise) begin
              if (sda == ACK) begin
                ptr <= ptr_n;
                shift <= mem[ptr_n];
                state <= RDATA;
              end else state <= WAIT_STOP;
            end
          end
          default: sda_oe <= 1'b0;
        endcase
    end
endmodule

// File: tb/tb_i2c_target_regs.sv
// tb_i2c_target_regs: directed I2C master transactions against the register target
module tb_i2c_target_regs;
  localparam time T = 50ns;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic m_scl = 1'b1;
  logic m_sda_low = 1'b0;
  int checks = 0;
  int errors = 0;
  int stb_cnt = 0;
  logic ack;
  logic [7:0] d;
  i2c_target_regs_if #(.AW(4)) bus ();
  i2c_target_regs #(.DEV_ADDR(7'h64), .AW(4), .RST_VAL(8'h00)) dut (.clk(clk), .rst(rst), .bus(bus));
  assign bus.scl_i = m_scl;
  assign bus.sda_i = ~(m_sda_low | bus.sda_oe);
  always #5ns clk = ~clk;
  always @(negedge clk) if (bus.wr_stb) stb_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic wbit(input logic b);
    m_sda_low = ~b;
    #T m_scl = 1'b1;
    #(2*T) m_scl = 1'b0;
    #T;
  endtask

  task automatic rbit(output logic b);
    m_sda_low = 1'b0;
    #T m_scl = 1'b1;
    #T b = bus.sda_i;
    #T m_scl = 1'b0;
    #T;
  endtask

  task automatic start();
    m_sda_low = 1'b0;
    #T m_scl = 1'b1;
    #T m_sda_low = 1'b1;
    #T m_scl = 1'b0;
    #T;
  endtask

  task automatic stop();
    m_sda_low = 1'b1;
    #T m_scl = 1'b1;
    #T m_sda_low = 1'b0;
    #(2*T);
  endtask

  task automatic wbyte(input logic [7:0] v, output logic a);
    for (int i = 7; i >= 0; i--) wbit(v[i]);
    rbit(a);
  endtask

  task automatic rbyte(input logic nack, output logic [7:0] v);
    for (int i = 7; i >= 0; i--) rbit(v[i]);
    wbit(nack);
  endtask

  initial begin
    #23ns;
    check("rst_sda_oe", bus.sda_oe, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_wr_stb", bus.wr_stb, 0);
    check("rst_wr_addr", bus.wr_addr, 0);
    check("rst_wr_data", bus.wr_data, 0);
    rst = 1'b0;
    #(4*T);
    start();
    wbyte(8'hC8, ack); check("w1_addr_ack", ack, 0);
    check("w1_busy", bus.busy, 1);
    wbyte(8'h05, ack); check("w1_ptr_ack", ack, 0);
    wbyte(8'hDB, ack); check("w1_data_ack", ack, 0);
    check("w1_stb_cnt", stb_cnt, 1);
    check("w1_wr_addr", bus.wr_addr, 5);
    check("w1_wr_data", bus.wr_data, 8'hDB);
    stop();
    check("w1_busy_stop", bus.busy, 0);
    start();
    wbyte(8'hC8, ack); check("r1_addr_ack", ack, 0);
    wbyte(8'h05, ack); check("r1_ptr_ack", ack, 0);
    start();
    wbyte(8'hC9, ack); check("r1_raddr_ack", ack, 0);
    rbyte(1'b1, d); check("r1_data", d, 8'hDB);
    check("r1_sda_released", bus.sda_oe, 0);
    stop();
    check("r1_busy_stop", bus.busy, 0);
    check("r1_no_stb", stb_cnt, 1);
    start();
    wbyte(8'hE8, ack); check("bad_addr_nack", ack, 1);
    check("bad_addr_busy", bus.busy, 0);
    wbyte(8'h00, ack); check("bad_addr_ignore", ack, 1);
    stop();
    check("bad_addr_no_stb", stb_cnt, 1);
    start();
    wbyte(8'hC8, ack);
    wbyte(8'h0F, ack);
    wbyte(8'h11, ack); check("wrap_d0_ack", ack, 0);
    check("wrap_d0_addr", bus.wr_addr, 15);
    wbyte(8'h22, ack); check("wrap_d1_ack", ack, 0);
    check("wrap_d1_addr", bus.wr_addr, 0);
    check("wrap_d1_data", bus.wr_data, 8'h22);
    stop();
    check("wrap_stb_cnt", stb_cnt, 3);
    start();
    wbyte(8'hC8, ack);
    wbyte(8'h0F, ack);
    start();
    wbyte(8'hC9, ack);
    rbyte(1'b0, d); check("wrap_rd15", d, 8'h11);
    rbyte(1'b1, d); check("wrap_rd0", d, 8'h22);
    stop();
    start();
    wbyte(8'hC8, ack); check("b2b_addr_ack", ack, 0);
    wbyte(8'h03, ack);
    wbyte(8'h93, ack); check("b2b_data_ack", ack, 0);
    stop();
    start();
    wbyte(8'hC8, ack);
    wbyte(8'h03, ack);
    start();
    wbyte(8'hC9, ack);
    rbyte(1'b1, d); check("b2b_rd", d, 8'h93);
    stop();
    start();
    for (int i = 7; i >= 0; i--) wbit(logic'(8'hC8 >> i));
    check("rst_mid_ack_driven", bus.sda_oe, 1);
    #3ns rst = 1'b1;
    #1ns check("rst_mid_ack_release", bus.sda_oe, 0);
    check("rst_mid_busy", bus.busy, 0);
    m_sda_low = 1'b0;
    #T m_scl = 1'b1;
    #T rst = 1'b0;
    #(2*T);
    start();
    wbyte(8'hC8, ack);
    wbyte(8'h00, ack);
    start();
    wbyte(8'hC9, ack); check("post_rst_ack", ack, 0);
    for (int i = 0; i < 16; i++) begin
      rbyte(i == 15, d);
      check($sformatf("post_rst_mem%0d", i), d, 0);
    end
    stop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/i2c_target_regs.md
Name: i2c_target_regs

Overview:
Synthesizable I2C target (responder) with an internal byte-wide register file, clocked from the system clock.
- Oversamples the bus and answers master transactions: pointer write, data write, and sequential read.
- Sits on the shared open-drain SDA/SCL pair opposite the existing I2C master model; the bench's pull-up/wired-AND resolves the bus.
- Also exposes a write-strobe side port so fabric logic can observe register updates.

Parameters:
- DEV_ADDR, 7'h64: 7-bit target address matched against the first byte after START.
- AW, 4: register pointer width; register file depth = 2**AW bytes.
- RST_VAL, 8'h00: reset value of every register-file byte.

Ports:
- clk  input  1  system clock; must be at least 16x the SCL frequency.
- rst  input  1  asynchronous, active-high reset.
- scl_i  input  1  sampled SCL line.
- sda_i  input  1  sampled SDA line.
- sda_oe  output  1  1 pulls SDA low (open-drain); 0 releases the line.
- wr_stb  output  1  one-cycle pulse when a data byte is committed to the register file.
- wr_addr  output  AW  register index of the committed byte; valid with wr_stb.
- wr_data  output  8  committed byte; valid with wr_stb.
- busy  output  1  1 from a matched address until STOP.

Behaviour:
- Reset values: sda_oe=0, wr_stb=0, wr_addr=0, wr_data=0, busy=0, pointer=0, state=IDLE, all registers=RST_VAL. Reset mid-transfer releases SDA immediately (asynchronous).
- Input synchronisation: 2-flop synchronizers on scl_i and sda_i, plus one history flop.
  - scl_rise / scl_fall are single-cycle pulses.
  - START = synchronized SDA falling while SCL high. STOP = SDA rising while SCL high.
  - Detection latency is 3 clk from the pin edge.
- Bit timing: SDA is sampled on scl_rise. Target-driven SDA changes only on scl_fall.
- Bit counter: 3 bits, MSB first. A byte is complete on the 8th scl_rise.
- States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT_STOP.
- IDLE -> ADDR on START.
- ADDR: shift 8 bits.
  - If [7:1]==DEV_ADDR: go to ADDR_ACK, set busy=1, latch R/W.
  - Else: go to WAIT_STOP with sda_oe held 0 (NACK).
- ADDR_ACK: set sda_oe=1 on the scl_fall after bit 8; release on the next scl_fall.
  - Then go to PTR if R/W=0.
  - Go to RDATA if R/W=1; load shift register with mem[ptr] and drive bit 7 on that same scl_fall.
- PTR: shift 8 bits; pointer <= byte[AW-1:0] (upper bits ignored). PTR_ACK acks exactly like ADDR_ACK, then goes to WDATA.
- WDATA: on the 8th bit:
  - mem[ptr] <= byte; pulse wr_stb with wr_addr=ptr and wr_data=byte.
  - ptr <= ptr+1, wrapping modulo 2**AW.
  - WDATA_ACK acks, then returns to WDATA.
- RDATA: drive sda_oe = ~shift[7] on each scl_fall; after 8 bits go to RDATA_ACK and release SDA.
  - On scl_rise, sample the master ACK.
  - SDA low: ptr <= ptr+1 (wrap), reload from mem[ptr+1], return to RDATA.
  - SDA high (NACK): go to WAIT_STOP.
- WAIT_STOP: sda_oe=0; ignore bits until START or STOP.
- START seen in any state (repeated START): go to ADDR, bit counter=0, sda_oe=0. Pointer is retained, so write-pointer + repeated-START + read works.
- STOP seen in any state: go to IDLE, sda_oe=0, busy=0; pointer is retained.
- Simultaneous scl_rise and START/STOP cannot occur by definition (SCL stable high). START/STOP take priority over bit handling.
- Read of a location in the same cycle it is written returns the new value (the write is committed before the ACK).

Decomposition:
- Shared package i2c_pkg:
  - state enum;
  - constants I2C_WRITE=0 and I2C_READ=1;
  - ACK=0 and NACK=1.
- Sub-module i2c_bus_sync: synchronizers plus the scl_rise, scl_fall, start_det and stop_det pulses. It is reusable by a future synthesizable master.
- Register file and FSM stay in i2c_target_regs.

Test Plan:
- Write 0x64+W, pointer 0x05, data 0xDB -> three ACKs; wr_stb once with wr_addr=5 and wr_data=0xDB; busy falls at STOP.
- Pointer 0x05, repeated START, 0x64+R, master NACK -> byte 0xDB driven on SDA; SSDA released at the NACK; state returns to IDLE at STOP.
- Address 0x74+W -> no ACK (SDA high on bit 9); no wr_stb; busy stays 0.
- Burst write at pointer 0x0F of 0x11, 0x22 -> mem[15]=0x11 and mem[0]=0x22 (wrap); then a sequential read from 0x0F returns 0x11, 0x22.
- Assert rst while the target drives an ACK low -> sda_oe=0 in the same cycle; all registers read back 0x00 afterwards.
- Two back-to-back transactions: write 0x64+W, pointer 0x03, data 0x93; then read from pointer 0x03 -> returns 0x93 (matches the master's write/read task sequence).
